// File: rtl/sc_fifo_ctrl_if.sv
// rtl/sc_fifo_ctrl_if.sv - request/strobe/status bundle between a FIFO user and sc_fifo_ctrl
interface sc_fifo_ctrl_if #(
  parameter int AWIDTH = 3
);
  logic              wr_req_i;
  logic              rd_req_i;
  logic              flush_i;
  logic              wr_en_o;
  logic              rd_en_o;
  logic [AWIDTH-1:0] wr_pntr_o;
  logic [AWIDTH-1:0] rd_pntr_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [AWIDTH:0]   usedw_o;
  logic              ovf_o;
  logic              unf_o;

  modport master (
    output wr_req_i, rd_req_i, flush_i,
    input  wr_en_o, rd_en_o, wr_pntr_o, rd_pntr_o, full_o, empty_o,
    input  almost_full_o, almost_empty_o, usedw_o, ovf_o, unf_o
  );

  modport slave (
    input  wr_req_i, rd_req_i, flush_i,
    output wr_en_o, rd_en_o, wr_pntr_o, rd_pntr_o, full_o, empty_o,
    output almost_full_o, almost_empty_o, usedw_o, ovf_o, unf_o
  );
endinterface

// File: rtl/sc_fifo_ctrl.sv
// rtl/sc_fifo_ctrl.sv - single-clock FIFO pointer/count/flag controller for an external RAM
// Optional sticky overflow/underflow flags: define SC_FIFO_CTRL_ERR_FLAGS_EN.
module sc_fifo_ctrl #(
  parameter int AWIDTH       = 3,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic            clk_i,
  input  logic            srst_i,
  sc_fifo_ctrl_if.slave   bus
);
  localparam logic [AWIDTH:0] DEPTH  = (AWIDTH+1)'(2**AWIDTH);
  localparam logic [AWIDTH:0] AF_LVL = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE_LVL = (AWIDTH+1)'(ALMOST_EMPTY);

  logic [AWIDTH-1:0] r_wr_pntr;
  logic [AWIDTH-1:0] r_rd_pntr;
  logic [AWIDTH:0]   r_usedw;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;

  logic              w_wr_en;
  logic              w_rd_en;
  logic [AWIDTH:0]   w_usedw_nxt;

  // Reset also blocks the strobes so no RAM write lands while contents are discarded.
  assign w_wr_en = bus.wr_req_i && !r_full  && !bus.flush_i && !srst_i;
  assign w_rd_en = bus.rd_req_i && !r_empty && !bus.flush_i && !srst_i;

  always_comb begin
    w_usedw_nxt = r_usedw;
    if (bus.flush_i) begin
      w_usedw_nxt = '0;
    end else if (w_wr_en && !w_rd_en) begin
      w_usedw_nxt = r_usedw + 1'b1;
    end else if (w_rd_en && !w_wr_en) begin
      w_usedw_nxt = r_usedw - 1'b1;
    end
  end

  // Flags decode the next count so they change on the same edge as usedw.
  always_ff @(posedge clk_i) begin
    if (srst_i || bus.flush_i) begin
      r_wr_pntr      <= '0;
      r_rd_pntr      <= '0;
      r_usedw        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_en) r_wr_pntr <= r_wr_pntr + 1'b1;
      if (w_rd_en) r_rd_pntr <= r_rd_pntr + 1'b1;
      r_usedw        <= w_usedw_nxt;
      r_full         <= (w_usedw_nxt == DEPTH);
      r_empty        <= (w_usedw_nxt == '0);
      r_almost_full  <= (w_usedw_nxt >= AF_LVL);
      r_almost_empty <= (w_usedw_nxt <  AE_LVL);
    end
  end

`ifdef SC_FIFO_CTRL_ERR_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (bus.wr_req_i && r_full  && !bus.flush_i) r_ovf <= 1'b1;
      if (bus.rd_req_i && r_empty && !bus.flush_i) r_unf <= 1'b1;
    end
  end

  assign bus.ovf_o = r_ovf;
  assign bus.unf_o = r_unf;
`else
  assign bus.ovf_o = 1'b0;
  assign bus.unf_o = 1'b0;
`endif

  assign bus.wr_en_o        = w_wr_en;
  assign bus.rd_en_o        = w_rd_en;
  assign bus.wr_pntr_o      = r_wr_pntr;
  assign bus.rd_pntr_o      = r_rd_pntr;
  assign bus.usedw_o        = r_usedw;
  assign bus.full_o         = r_full;
  assign bus.empty_o        = r_empty;
  assign bus.almost_full_o  = r_almost_full;
  assign bus.almost_empty_o = r_almost_empty;
endmodule

// File: tb/tb_sc_fifo_ctrl.sv
// tb/tb_sc_fifo_ctrl.sv - scoreboard bench for sc_fifo_ctrl with a queue-based FIFO model and attached RAM
module tb_sc_fifo_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk;
  logic srst;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] mem [DEPTH];

  sc_fifo_ctrl_if #(.AWIDTH(AW)) bus ();

  sc_fifo_ctrl #(.AWIDTH(AW), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output RAM driven only by the controller's strobes and pointers.
  always @(posedge clk) begin
    if (bus.wr_en_o) mem[bus.wr_pntr_o] <= wdata;
    if (bus.rd_en_o) rdata <= mem[bus.rd_pntr_o];
  end

  typedef struct {
    int usedw; int wp; int rp;
    int full; int empty; int af; int ae; int ovf; int unf;
    int wr_en; int rd_en; int rd_chk; int rdat;
  } exp_t;

  exp_t exp_q[$];
  exp_t drv_e;
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  // Reference model: stored words, total accepted writes/reads since last clear, sticky errors.
  int m_q[$];
  int m_wcnt = 0;
  int m_rcnt = 0;
  int m_ovf  = 0;
  int m_unf  = 0;
  int pend_chk  = 0;
  int pend_data = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input bit wr, input bit rd, input bit fl, input bit rst);
    int n;
    bit full_now, empty_now;
    @(posedge clk);
    #1;
    bus.wr_req_i = wr;
    bus.rd_req_i = rd;
    bus.flush_i  = fl;
    srst         = rst;
    wdata        = 8'($urandom);
    n            = m_q.size();
    full_now     = (n == DEPTH);
    empty_now    = (n == 0);
    drv_e.usedw  = n;
    drv_e.wp     = m_wcnt % DEPTH;
    drv_e.rp     = m_rcnt % DEPTH;
    drv_e.full   = int'(full_now);
    drv_e.empty  = int'(empty_now);
    drv_e.af     = int'(n >= AF);
    drv_e.ae     = int'(n < AE);
    drv_e.ovf    = m_ovf;
    drv_e.unf    = m_unf;
    drv_e.wr_en  = int'(wr && !full_now && !fl && !rst);
    drv_e.rd_en  = int'(rd && !empty_now && !fl && !rst);
    drv_e.rd_chk = pend_chk;
    drv_e.rdat   = pend_data;
    exp_q.push_back(drv_e);
    pend_chk = 0;
    if (rst) begin
      m_q.delete();
      m_wcnt = 0; m_rcnt = 0; m_ovf = 0; m_unf = 0;
    end else begin
`ifdef SC_FIFO_CTRL_ERR_FLAGS_EN
      if (wr && full_now && !fl) m_ovf = 1;
      if (rd && empty_now && !fl) m_unf = 1;
`endif
      if (fl) begin
        m_q.delete();
        m_wcnt = 0; m_rcnt = 0;
      end else begin
        if (drv_e.rd_en != 0) begin
          pend_data = m_q.pop_front();
          pend_chk  = 1;
          m_rcnt++;
        end
        if (drv_e.wr_en != 0) begin
          m_q.push_back(int'(wdata));
          m_wcnt++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("usedw",    int'(bus.usedw_o),        mon_e.usedw);
      chk("wr_pntr",  int'(bus.wr_pntr_o),      mon_e.wp);
      chk("rd_pntr",  int'(bus.rd_pntr_o),      mon_e.rp);
      chk("full",     int'(bus.full_o),         mon_e.full);
      chk("empty",    int'(bus.empty_o),        mon_e.empty);
      chk("alm_full", int'(bus.almost_full_o),  mon_e.af);
      chk("alm_empty",int'(bus.almost_empty_o), mon_e.ae);
      chk("ovf",      int'(bus.ovf_o),          mon_e.ovf);
      chk("unf",      int'(bus.unf_o),          mon_e.unf);
      chk("wr_en",    int'(bus.wr_en_o),        mon_e.wr_en);
      chk("rd_en",    int'(bus.rd_en_o),        mon_e.rd_en);
      if (mon_e.rd_chk != 0) chk("rdata", int'(rdata), mon_e.rdat);
    end
  end

  initial begin
    int pw;
    srst         = 1'b1;
    bus.wr_req_i = 1'b0;
    bus.rd_req_i = 1'b0;
    bus.flush_i  = 1'b0;
    wdata        = '0;
    repeat (2) @(posedge clk);

    step(0, 0, 0, 0);                        // reset state
    repeat (8) step(1, 0, 0, 0);             // fill to 8, wr pointer wraps
    step(1, 0, 0, 0);                        // write while full
    step(1, 1, 0, 0);                        // both while full
    repeat (7) step(0, 1, 0, 0);             // drain to empty
    step(1, 1, 0, 0);                        // both while empty
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);                        // read while empty
    step(0, 0, 1, 0);                        // flush zeroes pointers
    repeat (6) step(1, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0);             // usedw=5, wr=3, rd=6
    step(1, 0, 1, 0);                        // flush beats write
    repeat (4) step(1, 0, 0, 0);
    repeat (20) step(1, 1, 0, 0);            // steady count with wrapping pointers
    step(1, 1, 0, 1);                        // reset mid-traffic
    repeat (10) step(1, 1, 0, 0);

    for (int i = 0; i < 800; i++) begin
      pw = ((i / 60) % 2 == 0) ? 75 : 30;   // alternate fill-biased and drain-biased phases
      step($urandom_range(99, 0) < pw,
           $urandom_range(99, 0) < 100 - pw,
           $urandom_range(99, 0) < 3,
           $urandom_range(199, 0) < 2);
    end
    step(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
